// File: rtl/fully_pipelined_adder.sv
// fully_pipelined_adder: carry-pipelined ripple adder, one full-adder bit per stage.
// Define FULLY_PIPELINED_ADDER_VALID_EN to add the in_vld/out_vld valid pipeline.
module fully_pipelined_adder #(
    parameter int WIDTH = 3
) (
    output logic [WIDTH-1:0] s,
    output logic             carry,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             en,
    input  logic             clk,
    input  logic             rst_n
`ifdef FULLY_PIPELINED_ADDER_VALID_EN
   ,input  logic             in_vld,
    output logic             out_vld
`endif
);
    // Stage k keeps only the operand bits it and later stages still need; sum bits accumulate.
    for (genvar k = 0; k < WIDTH; k++) begin : st
        logic [WIDTH-1-k:0] ao, bo;
        logic [k:0] sn, so;
        logic ci, co, sum;
        if (k == 0) begin : g_first
            assign ao = a;
            assign bo = b;
            assign ci = c;
            assign sn = sum;
        end else begin : g_rest
            assign ci = st[k-1].co;
            assign sn = {sum, st[k-1].so};
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n) begin
                    ao <= '0;
                    bo <= '0;
                end else if (en) begin
                    ao <= st[k-1].ao[WIDTH-k:1];
                    bo <= st[k-1].bo[WIDTH-k:1];
                end
        end
        assign sum = ao[0] ^ bo[0] ^ ci;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                so <= '0;
                co <= 1'b0;
            end else if (en) begin
                so <= sn;
                co <= (ao[0] & bo[0]) | (ci & (ao[0] ^ bo[0]));
            end
    end

    assign s     = st[WIDTH-1].so;
    assign carry = st[WIDTH-1].co;

`ifdef FULLY_PIPELINED_ADDER_VALID_EN
    logic [WIDTH-1:0] vld_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            vld_q <= '0;
        else if (en)
            vld_q <= WIDTH'({vld_q, in_vld});
    assign out_vld = vld_q[WIDTH-1];
`endif
endmodule

// File: tb/tb_fully_pipelined_adder.sv
// tb_fully_pipelined_adder: directed-vector self-checking bench for fully_pipelined_adder.
// Compile with FULLY_PIPELINED_ADDER_VALID_EN to also exercise the valid pipeline.
module tb_fully_pipelined_adder;
    localparam int WIDTH = 3;
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b1;
    logic             c = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [WIDTH-1:0] s;
    logic             carry;
    logic [WIDTH:0]   res;
    int               tests = 0;
    int               fails = 0;
`ifdef FULLY_PIPELINED_ADDER_VALID_EN
    logic             in_vld = 1'b0;
    logic             out_vld;
`endif

    assign res = {carry, s};
    always #5 clk = ~clk;

    fully_pipelined_adder #(.WIDTH(WIDTH)) dut (
        .s(s), .carry(carry), .a(a), .b(b), .c(c), .en(en), .clk(clk), .rst_n(rst_n)
`ifdef FULLY_PIPELINED_ADDER_VALID_EN
       ,.in_vld(in_vld), .out_vld(out_vld)
`endif
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input logic xc);
        @(negedge clk);
        a = xa;
        b = xb;
        c = xc;
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                          input logic xc, input logic [7:0] exp);
        drive(xa, xb, xc);
        repeat (2) drive('0, '0, 1'b0);
        @(negedge clk);
        check(tag, 8'(res), exp);
    endtask

    initial begin
        #12;
        check("reset", 8'(res), 8'h0);
`ifdef FULLY_PIPELINED_ADDER_VALID_EN
        check("reset_vld", 8'(out_vld), 8'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        // first op after reset: zeroed registers must show until the result lands
        drive(3'd0, 3'd2, 1'b0);
        drive('0, '0, 1'b0);
        check("fill1", 8'(res), 8'h0);
        drive('0, '0, 1'b0);
        check("fill2", 8'(res), 8'h0);
        @(negedge clk);
        check("op_0_2_0", 8'(res), 8'h2);
        run_op("op_1_1_1", 3'd1, 3'd1, 1'b1, 8'h3);
        run_op("op_2_3_0", 3'd2, 3'd3, 1'b0, 8'h5);
        run_op("ovf_7_7_1", 3'd7, 3'd7, 1'b1, 8'hF);
        run_op("ovf_4_4_0", 3'd4, 3'd4, 1'b0, 8'h8);
        // back-to-back
        drive(3'd0, 3'd2, 1'b0);
        drive(3'd1, 3'd1, 1'b1);
        drive(3'd2, 3'd3, 1'b0);
        drive('0, '0, 1'b0);
        check("b2b_0", 8'(res), 8'h2);
        drive('0, '0, 1'b0);
        check("b2b_1", 8'(res), 8'h3);
        drive('0, '0, 1'b0);
        check("b2b_2", 8'(res), 8'h5);
        // stall with 4+4 at the output and 2+3, 5+1 in flight
        drive(3'd4, 3'd4, 1'b0);
        drive(3'd2, 3'd3, 1'b0);
        drive(3'd5, 3'd1, 1'b0);
        drive(3'd7, 3'd7, 1'b1);
        en = 1'b0;
        check("stall_entry", 8'(res), 8'h8);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_hold", 8'(res), 8'h8);
        end
        en = 1'b1;
        a = '0;
        b = '0;
        c = 1'b0;
        @(negedge clk);
        check("stall_resume1", 8'(res), 8'h5);
        @(negedge clk);
        check("stall_resume2", 8'(res), 8'h6);
        @(negedge clk);
        check("stall_ignored", 8'(res), 8'h0);
        // asynchronous reset with two ops in flight
        drive(3'd7, 3'd7, 1'b1);
        drive(3'd4, 3'd4, 1'b0);
        drive(3'd2, 3'd3, 1'b0);
        drive('0, '0, 1'b0);
        check("rst_pre", 8'(res), 8'hF);
        #2 rst_n = 1'b0;
        #1 check("rst_async", 8'(res), 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive('0, '0, 1'b0);
            check("rst_stale", 8'(res), 8'h0);
        end
        run_op("post_rst", 3'd1, 3'd1, 1'b1, 8'h3);
`ifdef FULLY_PIPELINED_ADDER_VALID_EN
        drive(3'd1, 3'd1, 1'b1);
        in_vld = 1'b1;
        drive('0, '0, 1'b0);
        in_vld = 1'b0;
        check("vld_e1", 8'(out_vld), 8'h0);
        drive('0, '0, 1'b0);
        check("vld_e2", 8'(out_vld), 8'h0);
        @(negedge clk);
        check("vld_hit", 8'(out_vld), 8'h1);
        check("vld_data", 8'(res), 8'h3);
        @(negedge clk);
        check("vld_after", 8'(out_vld), 8'h0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
